// File: rtl/fpm_rr_scheduler.sv
// Round-robin front end sharing one pipelined FP multiplier among NREQ requesters.
// A tag pipe matching the multiplier latency steers each result back to its owner.
module fpm_rr_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_c,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_data,
    output logic [3:0]           inflight,
    output logic                 idle
);

    localparam int unsigned DW  = 32;
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = 4;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] outstanding;
    tag_t [LAT:0]    tags;

    logic [NREQ-1:0] eligible_c;
    logic            win_c;
    logic [IDW-1:0]  win_id_c;
    logic            ret_c;
    logic [IDW-1:0]  ret_id_c;
    logic [NREQ-1:0] outstanding_nxt_c;
    logic [CW-1:0]   inflight_nxt_c;

    // Winner search starting at ptr; retire uses the final tag stage
    always_comb begin
        int unsigned cand;
        cand       = 0;
        eligible_c = req & ~outstanding;
        win_c      = 1'b0;
        win_id_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!win_c && eligible_c[IDW'(cand)]) begin
                win_c    = 1'b1;
                win_id_c = IDW'(cand);
            end
        end

        ret_c    = tags[LAT].valid;
        ret_id_c = tags[LAT].id;

        // A retiring requester keeps outstanding set for this edge, so it cannot win here
        outstanding_nxt_c = outstanding;
        if (ret_c) outstanding_nxt_c[ret_id_c] = 1'b0;
        if (win_c) outstanding_nxt_c[win_id_c] = 1'b1;

        inflight_nxt_c = inflight;
        if (win_c && !ret_c)      inflight_nxt_c = inflight + CW'(1);
        else if (!win_c && ret_c) inflight_nxt_c = inflight - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            outstanding <= '0;
            tags        <= '0;
            gnt         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            resp_valid  <= '0;
            resp_data   <= '0;
            inflight    <= '0;
            idle        <= 1'b1;
        end else if (clr) begin
            // Abort: operands and last result word hold, everything else clears
            ptr         <= '0;
            outstanding <= '0;
            tags        <= '0;
            gnt         <= '0;
            resp_valid  <= '0;
            inflight    <= '0;
            idle        <= 1'b1;
        end else begin
            tags        <= {tags[LAT-1:0], tag_t'{valid: win_c, id: win_id_c}};
            gnt         <= win_c ? (NREQ'(1) << win_id_c) : '0;
            resp_valid  <= ret_c ? (NREQ'(1) << ret_id_c) : '0;
            outstanding <= outstanding_nxt_c;
            inflight    <= inflight_nxt_c;
            idle        <= (inflight_nxt_c == CW'(0)) && !win_c;
            if (win_c) begin
                mul_a <= req_a[DW*win_id_c +: DW];
                mul_b <= req_b[DW*win_id_c +: DW];
                ptr   <= (win_id_c == IDW'(NREQ-1)) ? '0 : win_id_c + IDW'(1);
            end
            if (ret_c) resp_data <= mul_c;
        end
    end

endmodule

// File: tb/tb_fpm_rr_scheduler.sv
// Bench for fpm_rr_scheduler: pipelined multiplier stand-in plus a transaction-level
// scheduler model (queue of in-flight ops with due cycles) compared every cycle.
module tb_fpm_rr_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 4;

    logic                clk;
    logic                rst;
    logic                clr;
    logic [NREQ-1:0]     req;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     gnt;
    logic [31:0]         mul_a;
    logic [31:0]         mul_b;
    logic [31:0]         mul_c;
    logic [NREQ-1:0]     resp_valid;
    logic [31:0]         resp_data;
    logic [3:0]          inflight;
    logic                idle;

    int checks;
    int errors;

    fpm_rr_scheduler #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .clr(clr), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .resp_valid(resp_valid), .resp_data(resp_data), .inflight(inflight), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: known IEEE products, otherwise a scrambled word
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4080_0000) return 32'h4100_0000;
        if (a == 32'h42FA_4000 && b == 32'h4141_0000) return 32'h44BC_AA40;
        if (a == 32'h7F80_0000 && b == 32'h7380_0000) return 32'h7F80_0000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h1357_9BDF;
    endfunction

    logic [31:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < int'(LAT); i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_c = mpipe[LAT-1];

    // Reference model
    typedef struct {
        int          id;
        int          due;
        logic [31:0] data;
    } rec_t;

    rec_t            q[$];
    int              cyc;
    int              m_ptr;
    bit              m_out [NREQ];
    logic [NREQ-1:0] e_gnt, e_rv;
    logic [31:0]     e_rd, e_ma, e_mb;
    logic [3:0]      e_inf;
    logic            e_idle;

    task automatic model_reset();
        m_ptr = 0;
        foreach (m_out[i]) m_out[i] = 1'b0;
        q.delete();
        e_gnt = '0; e_rv = '0; e_rd = '0; e_ma = '0; e_mb = '0; e_inf = '0; e_idle = 1'b1;
    endtask

    task automatic model_step();
        int   w;
        rec_t r;
        cyc++;
        e_gnt = '0;
        e_rv  = '0;
        if (clr) begin
            m_ptr = 0;
            foreach (m_out[i]) m_out[i] = 1'b0;
            q.delete();
        end else begin
            w = -1;
            for (int k = 0; k < int'(NREQ); k++) begin
                int i;
                i = (m_ptr + k) % int'(NREQ);
                if (w < 0 && req[i] && !m_out[i]) w = i;
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                e_rv[r.id] = 1'b1;
                e_rd = r.data;
                m_out[r.id] = 1'b0;
            end
            if (w >= 0) begin
                e_gnt[w] = 1'b1;
                e_ma = req_a[32*w +: 32];
                e_mb = req_b[32*w +: 32];
                r.id = w; r.due = cyc + int'(LAT) + 1; r.data = fmul(e_ma, e_mb);
                q.push_back(r);
                m_out[w] = 1'b1;
                m_ptr = (w + 1) % int'(NREQ);
            end
        end
        e_inf  = 4'(q.size());
        e_idle = (q.size() == 0);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req[i] = 1'b1;
    endtask

    task automatic drain();
        req = '0;
        for (int n = 0; n < 20 && q.size() > 0; n++) tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; req = '0; req_a = '0; req_b = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle} !==
            {4'b0, 4'b0, 32'b0, 32'b0, 32'b0, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset got %h exp %h", {gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle},
                     {4'b0, 4'b0, 32'b0, 32'b0, 32'b0, 4'b0, 1'b1});
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        int g_n, r_n;
        logic [31:0] got;
        g_n = -1; r_n = -1; got = '0;
        set_op(0, 32'h4000_0000, 32'h4080_0000);
        for (int n = 0; n < int'(LAT) + 5; n++) begin
            tick();
            checks++;
            if ({gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle} !== {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle}) begin
                errors++;
                $display("FAIL single cyc=%0d got %h exp %h", cyc, {gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle},
                         {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle});
            end
            if (gnt[0] && g_n < 0) g_n = n;
            if (resp_valid[0] && r_n < 0) begin r_n = n; got = resp_data; end
            req = req & ~e_gnt;
        end
        checks++;
        if (g_n < 0 || r_n - g_n != int'(LAT) + 1) begin
            errors++;
            $display("FAIL single_latency got %0d exp %0d", r_n - g_n, LAT + 1);
        end
        checks++;
        if (got !== 32'h4100_0000) begin
            errors++;
            $display("FAIL single_data got %h exp 41000000", got);
        end
        checks++;
        if (inflight !== 4'd0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_idle got inflight=%0d idle=%b exp 0 1", inflight, idle);
        end
    endtask

    task automatic test_all_four();
        int peak, ng;
        int gseq [4];
        logic [31:0] got2;
        peak = 0; ng = 0; got2 = '0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_op(0, 32'h3F80_0000, 32'h4040_0000);
        set_op(1, 32'hC000_0000, 32'h4000_0000);
        set_op(2, 32'h42FA_4000, 32'h4141_0000);
        set_op(3, 32'h0000_0000, 32'h4120_0000);
        for (int n = 0; n < 2 * int'(LAT) + 4; n++) begin
            tick();
            checks++;
            if ({gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle} !== {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle}) begin
                errors++;
                $display("FAIL all_four cyc=%0d got %h exp %h", cyc, {gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle},
                         {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle});
            end
            for (int i = 0; i < int'(NREQ); i++)
                if (gnt[i] && ng < 4) begin gseq[ng] = i; ng++; end
            if (resp_valid[2]) got2 = resp_data;
            if (int'(inflight) > peak) peak = int'(inflight);
            req = req & ~e_gnt;
        end
        checks++;
        if (ng != 4 || gseq[0] != 0 || gseq[1] != 1 || gseq[2] != 2 || gseq[3] != 3) begin
            errors++;
            $display("FAIL all_four_order got n=%0d %0d%0d%0d%0d exp 0123", ng, gseq[0], gseq[1], gseq[2], gseq[3]);
        end
        checks++;
        if (peak != 4) begin
            errors++;
            $display("FAIL all_four_peak got %0d exp 4", peak);
        end
        checks++;
        if (got2 !== 32'h44BC_AA40) begin
            errors++;
            $display("FAIL all_four_data got %h exp 44bcaa40", got2);
        end
    endtask

    task automatic test_fairness();
        int seq[$];
        int bad;
        bad = 0;
        set_op(0, $urandom, $urandom);
        set_op(1, $urandom, $urandom);
        for (int n = 0; n < 40; n++) begin
            tick();
            checks++;
            if ({gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle} !== {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle}) begin
                errors++;
                $display("FAIL fairness cyc=%0d got %h exp %h", cyc, {gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle},
                         {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle});
            end
            if (gnt[0]) seq.push_back(0);
            if (gnt[1]) seq.push_back(1);
            for (int i = 0; i < 2; i++)
                if (e_gnt[i]) begin req_a[32*i +: 32] = $urandom; req_b[32*i +: 32] = $urandom; end
        end
        for (int k = 1; k < seq.size(); k++) if (seq[k] == seq[k-1]) bad++;
        checks++;
        if (seq.size() < 8 || bad != 0) begin
            errors++;
            $display("FAIL fairness_alternate got grants=%0d repeats=%0d exp >=8 0", seq.size(), bad);
        end
        drain();
    endtask

    task automatic test_special();
        logic [31:0] got;
        got = '0;
        set_op(3, 32'h7F80_0000, 32'h7380_0000);
        for (int n = 0; n < int'(LAT) + 4; n++) begin
            tick();
            checks++;
            if ({gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle} !== {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle}) begin
                errors++;
                $display("FAIL special cyc=%0d got %h exp %h", cyc, {gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle},
                         {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle});
            end
            if (resp_valid[3]) got = resp_data;
            req = req & ~e_gnt;
        end
        checks++;
        if (got !== 32'h7F80_0000) begin
            errors++;
            $display("FAIL special_inf got %h exp 7f800000", got);
        end
    endtask

    task automatic test_clr();
        int stale;
        stale = 0;
        set_op(0, $urandom, $urandom);
        set_op(1, $urandom, $urandom);
        set_op(2, $urandom, $urandom);
        for (int n = 0; n < 3; n++) begin
            tick();
            req = req & ~e_gnt;
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (inflight !== 4'd0 || gnt !== 4'b0 || resp_valid !== 4'b0) begin
            errors++;
            $display("FAIL clr_abort got inflight=%0d gnt=%b rv=%b exp 0 0000 0000", inflight, gnt, resp_valid);
        end
        set_op(1, 32'h3FC0_0000, 32'h4000_0000);
        for (int n = 0; n < int'(LAT) + 5; n++) begin
            tick();
            checks++;
            if ({gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle} !== {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle}) begin
                errors++;
                $display("FAIL clr cyc=%0d got %h exp %h", cyc, {gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle},
                         {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle});
            end
            if (n == 0) begin
                checks++;
                if (gnt !== 4'b0010) begin
                    errors++;
                    $display("FAIL clr_regrant got %b exp 0010", gnt);
                end
            end
            if (resp_valid[0] || resp_valid[2]) stale++;
            req = req & ~e_gnt;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL clr_stale got %0d exp 0", stale);
        end
    endtask

    task automatic test_async_reset();
        set_op(1, $urandom, $urandom);
        set_op(2, $urandom, $urandom);
        for (int n = 0; n < 2; n++) begin
            tick();
            req = req & ~e_gnt;
        end
        req = '0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle} !==
            {4'b0, 4'b0, 32'b0, 32'b0, 32'b0, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", {gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle},
                     {4'b0, 4'b0, 32'b0, 32'b0, 32'b0, 4'b0, 1'b1});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        set_op(0, $urandom, $urandom);
        set_op(3, $urandom, $urandom);
        for (int n = 0; n < int'(LAT) + 6; n++) begin
            tick();
            checks++;
            if ({gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle} !== {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle}) begin
                errors++;
                $display("FAIL async_reset cyc=%0d got %h exp %h", cyc, {gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle},
                         {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle});
            end
            if (n == 0) begin
                checks++;
                if (gnt !== 4'b0001) begin
                    errors++;
                    $display("FAIL async_reset_ptr got %b exp 0001", gnt);
                end
            end
            req = req & ~e_gnt;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clr = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < int'(NREQ); i++) begin
                if (e_gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else begin req_a[32*i +: 32] = $urandom; req_b[32*i +: 32] = $urandom; end
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    set_op(i, $urandom, $urandom);
                end
            end
            tick();
            checks++;
            if ({gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle} !== {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle}) begin
                errors++;
                $display("FAIL random cyc=%0d got %h exp %h", cyc, {gnt, resp_valid, resp_data, mul_a, mul_b, inflight, idle},
                         {e_gnt, e_rv, e_rd, e_ma, e_mb, e_inf, e_idle});
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_special();
        test_clr();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
